// File: rtl/mem_pkg.sv
// mem_pkg: shared types and the byte-lane merge used by the RAM arbiter.
package mem_pkg;
  typedef enum logic {IDLE, RMW} arb_state_t;
  localparam int NUM_PORTS = 2;
  function automatic logic [31:0] strb_merge(input logic [31:0] wdata, input logic [31:0] old, input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with the last-winner register.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NUM_PORTS-1:0] valid,
  output logic [NUM_PORTS-1:0] grant
);
  logic last_grant;
  always_comb begin
    grant = '0;
    if (en) grant = (valid == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : valid;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-ported word RAM between two byte-addressed ports,
// turning partial-strobe stores into a read-modify-write.
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic        req_we_0,
  input  logic [31:0] req_addr_0,
  input  logic [31:0] req_wdata_0,
  input  logic [3:0]  req_wstrb_0,
  output logic        resp_valid_0,
  output logic [31:0] resp_rdata_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic        req_we_1,
  input  logic [31:0] req_addr_1,
  input  logic [31:0] req_wdata_1,
  input  logic [3:0]  req_wstrb_1,
  output logic        resp_valid_1,
  output logic [31:0] resp_rdata_1,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  arb_state_t                      state, state_next;
  logic [NUM_PORTS-1:0]            grant, resp_valid_q;
  logic [NUM_PORTS-1:0][31:0]      resp_rdata_q;
  logic                            sel, accept, is_we, partial, rmw_owner, owner;
  logic [31:0]                     addr, wdata, rmw_data;
  logic [3:0]                      wstrb;
  logic [ADDR_W-1:0]               rmw_addr, word;
  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state == IDLE && !reset),
    .valid ({req_valid_1, req_valid_0}),
    .grant (grant)
  );
  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];
  assign accept = |grant;
  // With no grant sel stays 0, so the RAM address follows port 0 while idle.
  assign sel = grant[1];
  assign is_we = sel ? req_we_1 : req_we_0;
  assign addr = sel ? req_addr_1 : req_addr_0;
  assign wdata = sel ? req_wdata_1 : req_wdata_0;
  assign wstrb = sel ? req_wstrb_1 : req_wstrb_0;
  assign word = addr[ADDR_W+1:2];
  assign partial = is_we && wstrb != 4'h0 && wstrb != 4'hF;
  assign owner = (state == RMW) ? rmw_owner : sel;
  assign resp_valid_0 = resp_valid_q[0];
  assign resp_valid_1 = resp_valid_q[1];
  assign resp_rdata_0 = resp_rdata_q[0];
  assign resp_rdata_1 = resp_rdata_q[1];
  always_comb begin
    state_next = (state == IDLE && accept && partial) ? RMW : IDLE;
    ram_we = 1'b0;
    ram_addr = '0;
    ram_wdata = '0;
    if (!reset) begin
      ram_we = (state == RMW) || (accept && is_we && wstrb == 4'hF);
      ram_addr = {{(32-ADDR_W){1'b0}}, (state == RMW) ? rmw_addr : word};
      ram_wdata = (state == RMW) ? rmw_data : wdata;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rmw_addr <= '0;
      rmw_data <= '0;
      rmw_owner <= 1'b0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      state <= state_next;
      resp_valid_q <= '0;
      if (state == RMW || (accept && !partial)) begin
        resp_valid_q[owner] <= 1'b1;
        resp_rdata_q[owner] <= (state == RMW || is_we) ? 32'h0 : ram_rdata;
      end
      if (state == IDLE && accept && partial) begin
        rmw_addr <= word;
        rmw_data <= strb_merge(wdata, ram_rdata, wstrb);
        rmw_owner <= sel;
      end
    end
endmodule
